serial_add_sub: RTL
===================

// Module: serial_add_sub
// PURPOSE
//  Bit-serial adder/subtractor built around a single full-adder cell and a carry flip-flop.
//  Computes A+B or A-B (two's complement, B inverted, carry-in=1) LSB-first over WIDTH clocks.
//  Provides the sequential counterpart to the combinational adder chain: a small-area arithmetic
//  unit for the Hack datapath. Reports zr/ng flags plus carry and signed overflow.
// PARAMETERS
//  WIDTH   16   operand/result width in bits (>=2)
// PORTS
//  clk       in   1      single clock; all state updates on rising edge
//  reset     in   1      synchronous, active-high reset
//  start     in   1      request; accepted only when ready=1
//  sub       in   1      0: A+B, 1: A-B; sampled with start
//  a         in   WIDTH  operand A; sampled with start
//  b         in   WIDTH  operand B; sampled with start
//  ready     out  1      1 in IDLE (combinational from state)
//  done      out  1      one-cycle pulse: result/flags newly valid
//  result    out  WIDTH  sum/difference; held until next completion
//  cout      out  1      carry out of MSB (for sub: 1 = no borrow, a>=b unsigned)
//  overflow  out  1      signed overflow = carry into MSB XOR carry out of MSB
//  zr        out  1      result==0
//  ng        out  1      result[WIDTH-1]
// BEHAVIOUR
//  - One clock; reset synchronous, active-high. Reset: state=IDLE, ready=1, done=0,
//    result=0, cout=0, overflow=0, zr=0, ng=0, internal shift regs/count/carry=0.
//  - States: IDLE -> SHIFT on start&ready; SHIFT -> DONE after WIDTH shift edges; DONE -> IDLE
//    unconditionally on next edge.
//  - Accept edge: load opA<=a, opB<=(sub ? ~b : b), carry<=sub, count<=0.
//  - Each SHIFT edge: s=opA[0]^opB[0]^carry; carry<=maj(opA[0],opB[0],carry);
//    opA, opB shift right; s shifts into MSB of working sum reg; count++.
//  - On WIDTH-th shift edge: result<=final sum, cout<=final carry, overflow<=carry into MSB
//    XOR final carry, zr/ng from final sum; state<=DONE.
//  - done=1 exactly in DONE state (one cycle). Latency: accept edge k -> done high in the cycle
//    after edge k+WIDTH; next start accepted at edge k+WIDTH+2 earliest.
//  - ready=0 in SHIFT and DONE; start there is ignored (not queued). start held high through
//    DONE is accepted on the first IDLE edge.
//  - result/flags are unchanged while busy; they update only at completion, never mid-op.
//  - Operands a/b/sub may change freely after the accept edge without affecting the operation.
//  - reset mid-operation (any state) wins over everything: abort, go to reset values above,
//    no done pulse; ready=1 the cycle after the reset edge.
//  - All arithmetic is modulo 2^WIDTH; no saturation.
// TESTING
//  1 add a=0x0003,b=0x0004 -> result 0x0007, cout0, ovf0, zr0, ng0; done 1 cycle, exactly
//    WIDTH+1 edges after accept edge; ready low in between.
//  2 sub a=0x0005,b=0x0005 -> result 0x0000, zr1, ng0, cout1, ovf0.
//  3 add a=0x7FFF,b=0x0001 -> result 0x8000, ovf1, ng1, cout0; then add 0xFFFF+0x0001
//    -> 0x0000, cout1, ovf0, zr1.
//  4 sub a=0x0000,b=0x0001 -> result 0xFFFF, cout0 (borrow), ng1, ovf0; sub 0x8000-0x0001
//    -> 0x7FFF, ovf1.
//  5 start add 0x1234+0x1111, pulse start with 0xFFFF,0xFFFF during SHIFT -> ignored,
//    result 0x2345; a/b changed after accept -> no effect.
//  6 reset during 8th SHIFT cycle -> no done, all outputs 0, ready=1 next cycle; then
//    add 0x0001+0x0001 -> 0x0002 with normal latency.

Source files
------------

// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: one full-adder cell plus a carry flop, LSB-first over WIDTH clocks.
// Produces result with zr/ng/cout/overflow flags and a one-cycle done pulse.
module serial_add_sub #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             overflow,
   output logic             zr,
   output logic             ng
);

   localparam int unsigned CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] sum_q;
   logic [CW-1:0]    count;
   logic             carry;

   logic             s_bit;
   logic             c_next;
   logic [WIDTH-1:0] final_sum;

   // Single full-adder cell on the operand LSBs
   assign s_bit     = op_a[0] ^ op_b[0] ^ carry;
   assign c_next    = (op_a[0] & op_b[0]) | (op_a[0] & carry) | (op_b[0] & carry);
   assign final_sum = {s_bit, sum_q[WIDTH-1:1]};

   assign ready = (state == IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         op_a     <= '0;
         op_b     <= '0;
         sum_q    <= '0;
         count    <= '0;
         carry    <= 1'b0;
         done     <= 1'b0;
         result   <= '0;
         cout     <= 1'b0;
         overflow <= 1'b0;
         zr       <= 1'b0;
         ng       <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  // Subtraction as a + ~b + 1: inverted operand, carry-in of 1
                  op_a  <= a;
                  op_b  <= sub ? ~b : b;
                  carry <= sub;
                  count <= '0;
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               op_a  <= {1'b0, op_a[WIDTH-1:1]};
               op_b  <= {1'b0, op_b[WIDTH-1:1]};
               sum_q <= final_sum;
               carry <= c_next;
               count <= count + CW'(1);
               if (count == CW'(WIDTH - 1)) begin
                  // carry currently holds the carry into the MSB
                  result   <= final_sum;
                  cout     <= c_next;
                  overflow <= carry ^ c_next;
                  zr       <= (final_sum == '0);
                  ng       <= final_sum[WIDTH-1];
                  done     <= 1'b1;
                  state    <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
